// File: rtl/phase_controller_pkg.sv
// Shared types for the phase controller: phase enum, opcode encodings,
// control-output bundle and the phase/opcode decode used by the top level.
package phase_controller_pkg;

    typedef enum logic [3:0] {
        INST_ADDR  = 4'd0,
        INST_FETCH = 4'd1,
        INST_LOAD  = 4'd2,
        IDLE       = 4'd3,
        OP_ADDR    = 4'd4,
        OP_FETCH   = 4'd5,
        ALU_OP     = 4'd6,
        STORE      = 4'd7,
        HALTED     = 4'd8
    } phase_e;

    localparam logic [2:0] OP_HLT = 3'd0;
    localparam logic [2:0] OP_SKZ = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_LDA = 3'd5;
    localparam logic [2:0] OP_STO = 3'd6;
    localparam logic [2:0] OP_JMP = 3'd7;

    typedef struct packed {
        logic sel;
        logic rd;
        logic ld_ir;
        logic halt;
        logic inc_pc;
        logic ld_ac;
        logic ld_pc;
        logic wr;
        logic data_e;
    } ctrl_t;

    // Control values seen in INST_ADDR, which is also the reset state.
    localparam ctrl_t CTRL_RESET = 9'b1_0000_0000;

    function automatic logic is_aluop(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
    endfunction

    function automatic ctrl_t decode_ctrl(input phase_e ph, input logic [2:0] op,
                                          input logic zero);
        ctrl_t c;
        logic  aluop;
        c     = '0;
        aluop = is_aluop(op);
        case (ph)
            INST_ADDR:  c.sel = 1'b1;
            INST_FETCH: begin
                c.sel = 1'b1;
                c.rd  = 1'b1;
            end
            INST_LOAD, IDLE: begin
                c.sel   = 1'b1;
                c.rd    = 1'b1;
                c.ld_ir = 1'b1;
            end
            OP_ADDR: begin
                c.inc_pc = 1'b1;
                c.halt   = (op == OP_HLT);
            end
            OP_FETCH:   c.rd = aluop;
            ALU_OP: begin
                c.rd     = aluop;
                c.inc_pc = (op == OP_SKZ) && zero;
                c.ld_pc  = (op == OP_JMP);
                c.data_e = (op == OP_STO);
            end
            STORE: begin
                c.rd     = aluop;
                c.ld_ac  = aluop;
                c.ld_pc  = (op == OP_JMP);
                c.wr     = (op == OP_STO);
                c.data_e = (op == OP_STO);
            end
            HALTED:     c.halt = 1'b1;
            default:    c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/phase_counter.sv
// Three-bit free-running phase counter that wraps 7 -> 0 and freezes while
// hold_i is high.
module phase_counter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       hold_i,
    output logic [2:0] count_o
);

    logic [2:0] count_q;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 3'd0;
        end else if (!hold_i) begin
            count_q <= count_q + 3'd1;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/phase_controller.sv
// Eight-phase instruction sequencer with sticky or pulsed halt.
// Define PHASE_CTRL_REGOUT_EN to register all control outputs (same timing).
module phase_controller
    import phase_controller_pkg::*;
#(
    parameter bit HALT_STICKY = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] opcode,
    input  logic       zero,
    output logic       sel,
    output logic       rd,
    output logic       ld_ir,
    output logic       halt,
    output logic       inc_pc,
    output logic       ld_ac,
    output logic       ld_pc,
    output logic       wr,
    output logic       data_e,
    output logic [2:0] phase
);

    logic       halted_q;
    logic       halted_d;
    logic [2:0] count;
    phase_e     state;
    ctrl_t      ctrl;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            halted_q <= 1'b0;
        end else begin
            halted_q <= halted_d;
        end
    end

    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned and infers a latch.
    always_comb begin
        state    = halted_q ? HALTED : phase_e'({1'b0, count});
        halted_d = halted_q;
        if (HALT_STICKY && (state == OP_ADDR) && (opcode == OP_HLT)) begin
            halted_d = 1'b1;
        end
    end

    // Holding on the next-state value keeps the phase frozen at OP_ADDR from
    // the very first HALTED cycle.
    phase_counter u_phase_counter (
        .clk     (clk),
        .rst_n   (rst),
        .hold_i  (halted_d),
        .count_o (count)
    );

`ifdef PHASE_CTRL_REGOUT_EN
    phase_e     state_nxt;
    logic [2:0] count_nxt;
    ctrl_t      ctrl_q;

    always_comb begin
        count_nxt = halted_d ? count : count + 3'd1;
        state_nxt = halted_d ? HALTED : phase_e'({1'b0, count_nxt});
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl_q <= CTRL_RESET;
        end else begin
            ctrl_q <= decode_ctrl(state_nxt, opcode, zero);
        end
    end

    assign ctrl = ctrl_q;
`else
    assign ctrl = decode_ctrl(state, opcode, zero);
`endif

    assign {sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e} = ctrl;
    assign phase = count;

endmodule

// File: doc/phase_controller.md
PHASE_CONTROLLER -- requirements
Module: phase_controller

Interface
REQ-001 The block SHALL have parameter HALT_STICKY, default 1, which selects halt handling: 1 = hold HALTED until reset, 0 = pulse halt and continue.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, with all state updating on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-low (0 = reset).
REQ-004 The block SHALL have port opcode, input, 3 bits: instruction opcode, valid from INST_LOAD onward.
REQ-005 The block SHALL have port zero, input, 1 bit: accumulator-zero flag.
REQ-006 The block SHALL have outputs sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr and data_e, each 1 bit: datapath and program-counter controls.
REQ-007 The block SHALL have port phase, output, 3 bits: current phase, for debug.

Function
REQ-008 The block SHALL sequence eight phases, one per clk: INST_ADDR(0) -> INST_FETCH(1) -> INST_LOAD(2) -> IDLE(3) -> OP_ADDR(4) -> OP_FETCH(5) -> ALU_OP(6) -> STORE(7) -> INST_ADDR, wrapping 7 to 0.
REQ-009 Opcode encodings SHALL be HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7; ALUOP SHALL be defined as ADD, AND, XOR or LDA.
REQ-010 sel SHALL be 1 in phases 0-3 and 0 otherwise.
REQ-011 rd SHALL be 1 in phases 1-3, SHALL equal ALUOP in phases 5-7, and SHALL be 0 otherwise.
REQ-012 ld_ir SHALL be 1 in phases 2-3 only.
REQ-013 halt SHALL be 1 in OP_ADDR when opcode=HLT.
REQ-014 inc_pc SHALL be 1 in OP_ADDR, and 1 in ALU_OP when opcode=SKZ and zero=1; the SKZ case gives a net PC+2.
REQ-015 ld_ac SHALL be 1 in STORE when ALUOP.
REQ-016 ld_pc SHALL be 1 in ALU_OP and STORE when opcode=JMP.
REQ-017 wr SHALL be 1 in STORE when opcode=STO.
REQ-018 data_e SHALL be 1 in ALU_OP and STORE when opcode=STO.
REQ-019 With HALT_STICKY=1, OP_ADDR with HLT SHALL enter state HALTED next cycle.
REQ-020 In HALTED: halt=1, all other outputs 0, phase holds at 4, and the block SHALL remain there until rst.
REQ-021 With HALT_STICKY=0, halt SHALL pulse for one cycle and sequencing SHALL continue normally.
REQ-022 inc_pc and ld_pc SHALL never both be 1 in the same cycle.
REQ-023 wr and rd SHALL never both be 1 in the same cycle.
REQ-024 opcode SHALL be sampled only as the current input and not latched internally; the IR holds it stable.

Reset
REQ-025 rst=0 SHALL asynchronously force phase=INST_ADDR, leave HALTED, and force registered outputs to their phase-0 values (sel=1, all others 0).
REQ-026 rst asserted mid-instruction (any phase) SHALL abort the instruction with no wr or ld_pc pulse afterward.
REQ-027 The first post-reset rising edge SHALL advance the phase to INST_FETCH.

Configuration
REQ-028 With macro PHASE_CTRL_REGOUT_EN defined, all control outputs SHALL be registered, decoded from the next phase and the opcode, while keeping identical cycle alignment.
REQ-029 With PHASE_CTRL_REGOUT_EN undefined, control outputs SHALL be combinational decodes of phase, opcode and zero.
REQ-030 Waveforms SHALL be identical cycle-for-cycle with and without PHASE_CTRL_REGOUT_EN.

Structure
REQ-031 A shared package SHALL hold the phase enum (8 phases plus HALTED), the opcode constants and the ALUOP decode function.
REQ-032 A sub-module phase_counter (3-bit wrap counter with hold input) SHALL be used, with hold driven by HALTED.

Verification
REQ-033 Reset release, opcode=ADD, free-run 8 cycles -> sel=1 in phases 0-3, rd=1 in phases 1-3 and 5-7, ld_ac=1 only in phase 7, phase returns to 0 at cycle 8.
REQ-034 opcode=SKZ: zero=1 -> inc_pc in phases 4 and 6; zero=0 -> inc_pc in phase 4 only.
REQ-035 opcode=STO -> data_e=1 in phases 6-7, wr=1 in phase 7, rd=0 throughout phases 5-7.
REQ-036 opcode=JMP -> ld_pc=1 in phases 6-7, inc_pc=1 only in phase 4.
REQ-037 opcode=HLT: HALT_STICKY=1 -> halt stays 1 for 20 cycles with phase=4 until rst=0; HALT_STICKY=0 -> one-cycle halt, phase 5 follows.
REQ-038 rst=0 pulsed asynchronously in phase 6 with STO -> phase=0 immediately, no wr pulse; run the same test with and without PHASE_CTRL_REGOUT_EN and compare traces.
